redmule_mx_store_arbiter: RTL and testbench
===========================================

// Module: redmule_mx_store_arbiter
//
// PURPOSE
//  Schedules the MX output path onto the single Z store stream. Merges packed FP8 value beats
//  (DATAW_ALIGN bits) and the per-block 8-bit shared exponents. Exponents are packed into full
//  store beats, and the two sources are round-robin arbitrated onto one output stream.
//  Counts beats and bytes per job, flushes the final partial exponent beat, and signals job
//  completion to the controller. Sits between the MX output stage and the Z streamer.
//
// PARAMETERS
//  DATAW_ALIGN   512              store beat width in bits
//  EXP_PER_BEAT  DATAW_ALIGN/8    exponent bytes packed per store beat
//  CNT_W         16               width of job beat/byte counters
//
// PORTS
//  clk_i         in   1            clock
//  rst_ni        in   1            async reset, active low
//  clear_i       in   1            sync clear; same effect as reset
//  start_i       in   1            job start pulse; latches val_beats_i/exp_bytes_i
//  val_beats_i   in   CNT_W        number of value beats in job
//  exp_bytes_i   in   CNT_W        number of exponent bytes in job
//  val_valid_i   in   1            value beat valid
//  val_data_i    in   DATAW_ALIGN  value beat data
//  val_strb_i    in   DATAW_ALIGN/8 value beat byte strobe
//  val_ready_o   out  1            value beat accepted
//  exp_valid_i   in   1            exponent byte valid
//  exp_data_i    in   8            exponent byte
//  exp_ready_o   out  1            exponent byte accepted
//  out_valid_o   out  1            store beat valid
//  out_data_o    out  DATAW_ALIGN  store beat data
//  out_strb_o    out  DATAW_ALIGN/8 store beat strobe
//  out_sel_o     out  1            0 = value beat, 1 = exponent beat (address region select)
//  out_ready_i   in   1            downstream ready
//  busy_o        out  1            high from start acceptance until done
//  done_o        out  1            one-cycle pulse at job completion
//
// BEHAVIOUR
//  - Reset/clear: FSM=IDLE, counters=0, packer fill=0, exp beat pending=0, lock=0, rr=VAL;
//    all outputs 0.
//  - FSM IDLE: start_i latches counts and moves to RUN. RUN: both counters reach 0 and no
//    beat is pending -> DONE. DONE: done_o=1 for one cycle, then IDLE. busy_o=(state!=IDLE).
//  - start_i outside IDLE is ignored. A job with zero beats and zero bytes goes RUN->DONE with
//    done_o in the 2nd cycle after start.
//  - Packer: in RUN, exp_ready_o = !exp_pending && exp_rem!=0. An accepted byte is written to
//    lane fill, fill++, exp_rem--.
//    Beat goes pending when fill==EXP_PER_BEAT, or when exp_rem reaches 0 with fill>0
//    (partial flush). Strobe covers lanes [fill-1:0], unwritten lanes are zero, fill resets.
//  - Value requests are presented only while val_rem!=0; extra val_valid_i is not accepted.
//  - Arbiter: each cycle with out_valid_o=0 or an accepted handshake, a new grant is chosen.
//    Both sources requesting -> grant the one not matching rr. One source -> grant it.
//    On the out handshake, rr=granted source.
//  - Lock: once out_valid_o=1, grant, data, strb and sel hold stable until out_ready_i=1.
//  - val_ready_o = out_ready_i && grant==VAL (value path combinational, zero added latency).
//    The handshake decrements val_rem. The exp beat handshake clears exp_pending.
//  - An exponent byte cannot be accepted in the same cycle its packed beat is pending.
//    A byte can be accepted in the cycle after the pending beat's handshake.
//  - Counter underflow is impossible: requests are gated by rem!=0.
//  - Reset or clear mid-job drops all pending data; no done_o.
//
// CONFIGURATION
//  REDMULE_MX_STORE_PERF_EN defined: adds outputs perf_stall_o[31:0], which counts cycles
//  where out_valid_o && !out_ready_i, and perf_exp_beats_o[15:0], which counts exp beats sent.
//  Both are cleared on start_i, reset and clear_i.
//  Undefined: these ports and counters do not exist; behaviour is otherwise identical.
//
// TESTING
//  - Single-byte flush: val_beats=2, exp_bytes=1, all sources always valid, out_ready=1.
//    Expect 2 val beats + 1 exp beat with strb=64'h1, then done_o one cycle later.
//  - Full packing: exp_bytes=128 with bytes 0..127, val_beats=0. Expect 2 exp beats with
//    strb all ones; beat0 lane k=k and beat1 lane k=64+k.
//  - Round-robin: both sources continuously pending. Expect out_sel_o to alternate 0,1,0,1.
//  - Backpressure: out_ready_i=0 for 5 cycles with out_valid_o=1.
//    Expect data/strb/sel stable; val_ready_o=0 and exp_ready_o=0 on the pending beat.
//  - Zero job: start with 0/0. Expect busy_o high for 2 cycles, done_o pulse, no out_valid_o.
//  - Clear mid-job after 1 of 4 val beats. Expect busy_o=0 next cycle, no done_o, and no
//    out_valid_o until the next start_i.

Source files
------------

// File: rtl/redmule_mx_store_arbiter.sv
// redmule_mx_store_arbiter
// Schedules the MX output path onto the single Z store stream. Packed FP8 value
// beats pass straight through. Per-block 8-bit shared exponents are packed into
// full store beats. The two sources are round-robin arbitrated onto one stream.
// The block tracks beats/bytes per job, flushes a trailing partial exponent beat
// and pulses done_o when the job has fully drained.
// Optional feature: define REDMULE_MX_STORE_PERF_EN to add the perf_stall_o and
// perf_exp_beats_o counters.

module redmule_mx_store_arbiter #(
    parameter int unsigned DATAW_ALIGN  = 512,
    parameter int unsigned EXP_PER_BEAT = DATAW_ALIGN / 8,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic [CNT_W-1:0]           val_beats_i,
    input  logic [CNT_W-1:0]           exp_bytes_i,
    input  logic                       val_valid_i,
    input  logic [DATAW_ALIGN-1:0]     val_data_i,
    input  logic [DATAW_ALIGN/8-1:0]   val_strb_i,
    output logic                       val_ready_o,
    input  logic                       exp_valid_i,
    input  logic [7:0]                 exp_data_i,
    output logic                       exp_ready_o,
    output logic                       out_valid_o,
    output logic [DATAW_ALIGN-1:0]     out_data_o,
    output logic [DATAW_ALIGN/8-1:0]   out_strb_o,
    output logic                       out_sel_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic                       done_o
`ifdef REDMULE_MX_STORE_PERF_EN
    ,
    output logic [31:0]                perf_stall_o,
    output logic [15:0]                perf_exp_beats_o
`endif
);

    localparam int unsigned STRB_W = DATAW_ALIGN / 8;
    localparam int unsigned FILL_W = $clog2(EXP_PER_BEAT + 1);
    localparam int unsigned LANE_W = $clog2(EXP_PER_BEAT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic SRC_VAL = 1'b0;
    localparam logic SRC_EXP = 1'b1;

    // Registered state
    logic [1:0]             state_q,       state_d;
    logic [CNT_W-1:0]       val_rem_q,     val_rem_d;
    logic [CNT_W-1:0]       exp_rem_q,     exp_rem_d;
    logic [FILL_W-1:0]      fill_q,        fill_d;
    logic [DATAW_ALIGN-1:0] exp_buf_q,     exp_buf_d;
    logic [STRB_W-1:0]      exp_strb_q,    exp_strb_d;
    logic                   exp_pending_q, exp_pending_d;
    logic                   lock_q,        lock_d;
    logic                   grant_q,       grant_d;
    logic                   rr_q,          rr_d;

    // Combinational helpers
    logic                   run;
    logic                   val_req;
    logic                   exp_req;
    logic                   grant;
    logic                   out_hs;
    logic                   val_hs;
    logic                   exp_hs;
    logic                   exp_acc;
    logic [FILL_W-1:0]      fill_inc;
    logic [EXP_PER_BEAT:0]  strb_wide;

    assign run      = (state_q == ST_RUN);
    assign val_req  = run && (val_rem_q != '0) && val_valid_i;
    assign exp_req  = exp_pending_q;
    assign fill_inc = fill_q + FILL_W'(1);

    // Grant selection: a locked beat keeps its source, otherwise round-robin
    // between the two requesters, or the single requester if only one asks.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = SRC_VAL;
        if (lock_q) begin
            grant = grant_q;
        end else if (val_req && exp_req) begin
            grant = ~rr_q;
        end else if (exp_req) begin
            grant = SRC_EXP;
        end
    end

    assign out_valid_o = (grant == SRC_EXP) ? exp_req : val_req;
    assign out_sel_o   = out_valid_o && (grant == SRC_EXP);
    assign out_data_o  = !out_valid_o          ? '0 :
                         (grant == SRC_EXP)    ? exp_buf_q : val_data_i;
    assign out_strb_o  = !out_valid_o          ? '0 :
                         (grant == SRC_EXP)    ? exp_strb_q : val_strb_i;

    // Value path is a combinational pass-through gated by the grant, so it adds
    // no latency; it only opens while value beats are still owed for the job.
    assign val_ready_o = run && (val_rem_q != '0) && out_ready_i && (grant == SRC_VAL);
    assign exp_ready_o = run && !exp_pending_q && (exp_rem_q != '0);

    assign out_hs  = out_valid_o && out_ready_i;
    assign val_hs  = out_hs && (grant == SRC_VAL);
    assign exp_hs  = out_hs && (grant == SRC_EXP);
    assign exp_acc = exp_ready_o && exp_valid_i;

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);

    // Strobe mask covering lanes [fill_inc-1:0] of the beat being closed.
    always_comb begin
        strb_wide = ((EXP_PER_BEAT + 1)'(1) << fill_inc) - (EXP_PER_BEAT + 1)'(1);
    end

    // Next-state logic: counters, exponent packer, lock/round-robin, job FSM.
    always_comb begin
        state_d       = state_q;
        val_rem_d     = val_rem_q;
        exp_rem_d     = exp_rem_q;
        fill_d        = fill_q;
        exp_buf_d     = exp_buf_q;
        exp_strb_d    = exp_strb_q;
        exp_pending_d = exp_pending_q;
        lock_d        = out_valid_o && !out_ready_i;
        grant_d       = grant;
        rr_d          = rr_q;

        if (out_hs) begin
            rr_d = grant;
        end

        if (val_hs) begin
            val_rem_d = val_rem_q - CNT_W'(1);
        end

        // Sending the exponent beat frees the buffer; it restarts all-zero so
        // lanes a later partial beat does not write read back as zero.
        if (exp_hs) begin
            exp_pending_d = 1'b0;
            exp_buf_d     = '0;
            exp_strb_d    = '0;
        end

        // Pack an accepted byte into the next lane; close the beat when full or
        // when it holds the job's last byte.
        if (exp_acc) begin
            exp_buf_d[8*fill_q[LANE_W-1:0] +: 8] = exp_data_i;
            exp_rem_d = exp_rem_q - CNT_W'(1);
            if ((fill_inc == FILL_W'(EXP_PER_BEAT)) || (exp_rem_d == '0)) begin
                exp_pending_d = 1'b1;
                exp_strb_d    = strb_wide[STRB_W-1:0];
                fill_d        = '0;
            end else begin
                fill_d = fill_inc;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d       = ST_RUN;
                    val_rem_d     = val_beats_i;
                    exp_rem_d     = exp_bytes_i;
                    fill_d        = '0;
                    exp_buf_d     = '0;
                    exp_strb_d    = '0;
                    exp_pending_d = 1'b0;
                    lock_d        = 1'b0;
                end
            end
            ST_RUN: begin
                // Uses next-state values so done_o follows the last beat by one cycle.
                if ((val_rem_d == '0) && (exp_rem_d == '0) && !exp_pending_d) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; clear_i behaves exactly like reset and drops in-flight data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            val_rem_q     <= '0;
            exp_rem_q     <= '0;
            fill_q        <= '0;
            // NOTE: the exponent buffer is reset (not left uninitialised like a
            // RAM) because unwritten lanes of a partial beat must read as zero.
            exp_buf_q     <= '0;
            exp_strb_q    <= '0;
            exp_pending_q <= 1'b0;
            lock_q        <= 1'b0;
            grant_q       <= SRC_VAL;
            rr_q          <= SRC_VAL;
        end else if (clear_i) begin
            state_q       <= ST_IDLE;
            val_rem_q     <= '0;
            exp_rem_q     <= '0;
            fill_q        <= '0;
            exp_buf_q     <= '0;
            exp_strb_q    <= '0;
            exp_pending_q <= 1'b0;
            lock_q        <= 1'b0;
            grant_q       <= SRC_VAL;
            rr_q          <= SRC_VAL;
        end else begin
            state_q       <= state_d;
            val_rem_q     <= val_rem_d;
            exp_rem_q     <= exp_rem_d;
            fill_q        <= fill_d;
            exp_buf_q     <= exp_buf_d;
            exp_strb_q    <= exp_strb_d;
            exp_pending_q <= exp_pending_d;
            lock_q        <= lock_d;
            grant_q       <= grant_d;
            rr_q          <= rr_d;
        end
    end

`ifdef REDMULE_MX_STORE_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_exp_beats_q;

    // Performance counters, restarted whenever a new job is accepted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_q     <= '0;
            perf_exp_beats_q <= '0;
        end else if (clear_i || (start_i && (state_q == ST_IDLE))) begin
            perf_stall_q     <= '0;
            perf_exp_beats_q <= '0;
        end else begin
            if (out_valid_o && !out_ready_i) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (exp_hs) begin
                perf_exp_beats_q <= perf_exp_beats_q + 16'd1;
            end
        end
    end

    assign perf_stall_o     = perf_stall_q;
    assign perf_exp_beats_o = perf_exp_beats_q;
`endif

endmodule

// File: tb/tb_redmule_mx_store_arbiter.sv
// Directed bench for redmule_mx_store_arbiter: flush, packing, round-robin,
// backpressure lock, zero-length job and clear mid-job.
`timescale 1ns/1ps

module tb_redmule_mx_store_arbiter;

    localparam int DW = 512;
    localparam int SW = DW / 8;
    localparam int CW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          start_i;
    logic [CW-1:0] val_beats_i;
    logic [CW-1:0] exp_bytes_i;
    logic          val_valid_i;
    logic [DW-1:0] val_data_i;
    logic [SW-1:0] val_strb_i;
    logic          val_ready_o;
    logic          exp_valid_i;
    logic [7:0]    exp_data_i;
    logic          exp_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [SW-1:0] out_strb_o;
    logic          out_sel_o;
    logic          out_ready_i;
    logic          busy_o;
    logic          done_o;

    int checks   = 0;
    int failures = 0;

    // Beat log filled by run_job
    logic          sel_log  [16];
    logic [DW-1:0] data_log [16];
    logic [SW-1:0] strb_log [16];
    int            cyc_log  [16];
    int            n_beats;
    int            done_cyc;

    redmule_mx_store_arbiter #(
        .DATAW_ALIGN (DW),
        .CNT_W       (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .val_beats_i (val_beats_i),
        .exp_bytes_i (exp_bytes_i),
        .val_valid_i (val_valid_i),
        .val_data_i  (val_data_i),
        .val_strb_i  (val_strb_i),
        .val_ready_o (val_ready_o),
        .exp_valid_i (exp_valid_i),
        .exp_data_i  (exp_data_i),
        .exp_ready_o (exp_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_strb_o  (out_strb_o),
        .out_sel_o   (out_sel_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Presents a start pulse in the current (call it cycle 0) cycle.
    task automatic start_job(input logic [CW-1:0] vb, input logic [CW-1:0] eb);
        @(negedge clk_i);
        start_i     = 1'b1;
        val_beats_i = vb;
        exp_bytes_i = eb;
    endtask

    // Runs a job to done_o, logging every store handshake. val_valid_i rises once
    // val_gate exponent bytes were accepted; exponent bytes count up from exp_base.
    task automatic run_job(input int val_gate, input logic [7:0] exp_base, input int max_cyc);
        int exp_cnt;
        int val_cnt;
        exp_cnt  = 0;
        val_cnt  = 0;
        n_beats  = 0;
        done_cyc = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk_i);
            start_i     = 1'b0;
            val_valid_i = (exp_cnt >= val_gate);
            val_data_i  = {16{32'hC0DE0000 + 32'(val_cnt)}};
            exp_data_i  = exp_base + 8'(exp_cnt);
            #1;
            if (out_valid_o && out_ready_i && n_beats < 16) begin
                sel_log[n_beats]  = out_sel_o;
                data_log[n_beats] = out_data_o;
                strb_log[n_beats] = out_strb_o;
                cyc_log[n_beats]  = c;
                n_beats++;
            end
            if (val_valid_i && val_ready_o) val_cnt++;
            if (exp_valid_i && exp_ready_o) exp_cnt++;
            if (done_o) begin
                done_cyc = c;
                break;
            end
        end
        if (done_cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL job_timeout: got no done_o expected done_o within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        clear_i     = 1'b0;
        start_i     = 1'b0;
        val_beats_i = '0;
        exp_bytes_i = '0;
        val_valid_i = 1'b1;
        val_data_i  = {16{32'hDEADBEEF}};
        val_strb_i  = '1;
        exp_valid_i = 1'b1;
        exp_data_i  = 8'h55;
        out_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid_o); end
        checks++; if (val_ready_o !== 1'b0) begin failures++; $display("FAIL rst_val_ready: got %b expected 0", val_ready_o); end
        checks++; if (exp_ready_o !== 1'b0) begin failures++; $display("FAIL rst_exp_ready: got %b expected 0", exp_ready_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", done_o); end
        checks++; if (out_data_o !== '0) begin failures++; $display("FAIL rst_out_data: got %h expected 0", out_data_o); end
        checks++; if (out_strb_o !== '0) begin failures++; $display("FAIL rst_out_strb: got %h expected 0", out_strb_o); end
        checks++; if (out_sel_o !== 1'b0) begin failures++; $display("FAIL rst_out_sel: got %b expected 0", out_sel_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        #1;
        checks++; if ({out_valid_o, val_ready_o, exp_ready_o, busy_o, done_o} !== 5'b0) begin
            failures++; $display("FAIL idle_after_rst: got %b expected 00000", {out_valid_o, val_ready_o, exp_ready_o, busy_o, done_o});
        end
        val_valid_i = 1'b0;
        exp_valid_i = 1'b0;
    endtask

    task automatic test_single_flush();
        out_ready_i = 1'b1;
        exp_valid_i = 1'b1;
        val_strb_i  = '1;
        start_job(16'd2, 16'd1);
        run_job(0, 8'hA5, 50);
        checks++; if (n_beats !== 3) begin failures++; $display("FAIL flush_beats: got %0d expected 3", n_beats); end
        checks++; if ({sel_log[0], sel_log[1], sel_log[2]} !== 3'b010) begin
            failures++; $display("FAIL flush_sel: got %b expected 010", {sel_log[0], sel_log[1], sel_log[2]});
        end
        checks++; if (strb_log[1] !== 64'h1) begin failures++; $display("FAIL flush_exp_strb: got %h expected 1", strb_log[1]); end
        checks++; if (data_log[1] !== DW'(8'hA5)) begin failures++; $display("FAIL flush_exp_data: got %h expected a5", data_log[1]); end
        checks++; if (data_log[0] !== {16{32'hC0DE0000}}) begin failures++; $display("FAIL flush_val0_data: got %h", data_log[0]); end
        checks++; if (data_log[2] !== {16{32'hC0DE0001}}) begin failures++; $display("FAIL flush_val1_data: got %h", data_log[2]); end
        checks++; if (strb_log[0] !== {SW{1'b1}}) begin failures++; $display("FAIL flush_val_strb: got %h expected all ones", strb_log[0]); end
        checks++; if (cyc_log[2] !== 3 || done_cyc !== 4) begin
            failures++; $display("FAIL flush_done_timing: got last=%0d done=%0d expected last=3 done=4", cyc_log[2], done_cyc);
        end
        exp_valid_i = 1'b0;
    endtask

    task automatic test_full_packing();
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;
        for (int k = 0; k < 64; k++) begin
            exp0[8*k +: 8] = 8'(k);
            exp1[8*k +: 8] = 8'(64 + k);
        end
        out_ready_i = 1'b1;
        exp_valid_i = 1'b1;
        start_job(16'd0, 16'd128);
        run_job(0, 8'h00, 300);
        checks++; if (n_beats !== 2) begin failures++; $display("FAIL pack_beats: got %0d expected 2", n_beats); end
        checks++; if ({sel_log[0], sel_log[1]} !== 2'b11) begin failures++; $display("FAIL pack_sel: got %b expected 11", {sel_log[0], sel_log[1]}); end
        checks++; if (strb_log[0] !== {SW{1'b1}} || strb_log[1] !== {SW{1'b1}}) begin
            failures++; $display("FAIL pack_strb: got %h / %h expected all ones", strb_log[0], strb_log[1]);
        end
        checks++; if (data_log[0] !== exp0) begin failures++; $display("FAIL pack_beat0: got %h expected %h", data_log[0], exp0); end
        checks++; if (data_log[1] !== exp1) begin failures++; $display("FAIL pack_beat1: got %h expected %h", data_log[1], exp1); end
        checks++; if (cyc_log[0] !== 65 || cyc_log[1] !== 130 || done_cyc !== 131) begin
            failures++; $display("FAIL pack_timing: got %0d/%0d/%0d expected 65/130/131", cyc_log[0], cyc_log[1], done_cyc);
        end
        exp_valid_i = 1'b0;
    endtask

    // Previous job ended on an exponent beat, so the value source wins first.
    task automatic test_round_robin();
        logic [4:0]    seq;
        logic [DW-1:0] exp0;
        for (int k = 0; k < 64; k++) exp0[8*k +: 8] = 8'(k);
        out_ready_i = 1'b1;
        exp_valid_i = 1'b1;
        start_job(16'd3, 16'd65);
        run_job(64, 8'h00, 200);
        for (int i = 0; i < 5; i++) seq[4-i] = sel_log[i];
        checks++; if (n_beats !== 5) begin failures++; $display("FAIL rr_beats: got %0d expected 5", n_beats); end
        checks++; if (seq !== 5'b01010) begin failures++; $display("FAIL rr_sel_seq: got %b expected 01010", seq); end
        checks++; if (cyc_log[0] !== 65 || cyc_log[4] !== 69) begin
            failures++; $display("FAIL rr_timing: got first=%0d last=%0d expected 65/69", cyc_log[0], cyc_log[4]);
        end
        checks++; if (data_log[1] !== exp0) begin failures++; $display("FAIL rr_full_beat: got %h", data_log[1]); end
        checks++; if (strb_log[3] !== 64'h1 || data_log[3] !== DW'(8'd64)) begin
            failures++; $display("FAIL rr_partial_beat: got strb=%h data=%h expected strb=1 data=40", strb_log[3], data_log[3]);
        end
        checks++; if (done_cyc !== 70) begin failures++; $display("FAIL rr_done: got %0d expected 70", done_cyc); end
        exp_valid_i = 1'b0;
        val_valid_i = 1'b0;
    endtask

    // A value beat stalled by out_ready_i=0 must stay granted even after an
    // exponent beat becomes pending with the round-robin pointing at it.
    task automatic test_backpressure();
        logic [DW-1:0] bp_data;
        logic [SW-1:0] bp_strb;
        bp_data     = {8{64'h0123_4567_89AB_CDEF}};
        bp_strb     = {8{8'hF0}};
        out_ready_i = 1'b0;
        val_valid_i = 1'b1;
        val_data_i  = bp_data;
        val_strb_i  = bp_strb;
        exp_valid_i = 1'b1;
        exp_data_i  = 8'h3C;
        start_job(16'd1, 16'd1);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            checks++; if ({out_valid_o, out_sel_o, val_ready_o} !== 3'b100) begin
                failures++; $display("FAIL bp_hold_ctrl c%0d: got valid/sel/vready=%b expected 100", c, {out_valid_o, out_sel_o, val_ready_o});
            end
            checks++; if (out_data_o !== bp_data || out_strb_o !== bp_strb) begin
                failures++; $display("FAIL bp_hold_data c%0d: got strb=%h expected %h", c, out_strb_o, bp_strb);
            end
            if (c >= 2) begin
                checks++; if (exp_ready_o !== 1'b0) begin failures++; $display("FAIL bp_exp_ready c%0d: got %b expected 0", c, exp_ready_o); end
            end
        end
        @(negedge clk_i);
        out_ready_i = 1'b1;
        #1;
        checks++; if ({out_valid_o, out_sel_o, val_ready_o} !== 3'b101) begin
            failures++; $display("FAIL bp_release: got valid/sel/vready=%b expected 101", {out_valid_o, out_sel_o, val_ready_o});
        end
        @(negedge clk_i);
        val_valid_i = 1'b0;
        #1;
        checks++; if ({out_valid_o, out_sel_o, val_ready_o} !== 3'b110 || out_strb_o !== 64'h1 || out_data_o !== DW'(8'h3C)) begin
            failures++; $display("FAIL bp_exp_beat: got valid/sel/vready=%b strb=%h expected 110 strb=1 data=3c", {out_valid_o, out_sel_o, val_ready_o}, out_strb_o);
        end
        @(negedge clk_i);
        #1;
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL bp_done: got %b expected 1", done_o); end
        exp_valid_i = 1'b0;
        val_strb_i  = '1;
    endtask

    // Zero-length job, with a second start presented while running (ignored).
    task automatic test_zero_job();
        out_ready_i = 1'b1;
        val_valid_i = 1'b1;
        exp_valid_i = 1'b1;
        start_job(16'd0, 16'd0);
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL zero_c0_busy: got %b expected 0", busy_o); end
        @(negedge clk_i);
        start_i     = 1'b1;
        val_beats_i = 16'd5;
        exp_bytes_i = 16'd5;
        #1;
        checks++; if ({busy_o, done_o, out_valid_o} !== 3'b100) begin
            failures++; $display("FAIL zero_c1: got busy/done/valid=%b expected 100", {busy_o, done_o, out_valid_o});
        end
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        checks++; if ({busy_o, done_o, out_valid_o} !== 3'b110) begin
            failures++; $display("FAIL zero_c2: got busy/done/valid=%b expected 110", {busy_o, done_o, out_valid_o});
        end
        for (int c = 3; c <= 4; c++) begin
            @(negedge clk_i);
            #1;
            checks++; if ({busy_o, done_o, out_valid_o} !== 3'b000) begin
                failures++; $display("FAIL zero_c%0d: got busy/done/valid=%b expected 000", c, {busy_o, done_o, out_valid_o});
            end
        end
        exp_valid_i = 1'b0;
    endtask

    task automatic test_clear_mid_job();
        int stray;
        stray       = 0;
        out_ready_i = 1'b1;
        val_valid_i = 1'b1;
        exp_valid_i = 1'b0;
        start_job(16'd4, 16'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        checks++; if ({out_valid_o, val_ready_o, out_sel_o} !== 3'b110) begin
            failures++; $display("FAIL clr_first_beat: got valid/vready/sel=%b expected 110", {out_valid_o, val_ready_o, out_sel_o});
        end
        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL clr_busy: got %b expected 0", busy_o); end
        for (int c = 0; c < 8; c++) begin
            if (out_valid_o || done_o || busy_o || val_ready_o) stray++;
            @(negedge clk_i);
            #1;
        end
        checks++; if (stray !== 0) begin failures++; $display("FAIL clr_quiet: got %0d active cycles expected 0", stray); end
        start_job(16'd1, 16'd0);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        checks++; if ({out_valid_o, out_sel_o, val_ready_o} !== 3'b101) begin
            failures++; $display("FAIL clr_restart: got valid/sel/vready=%b expected 101", {out_valid_o, out_sel_o, val_ready_o});
        end
        @(negedge clk_i);
        #1;
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL clr_restart_done: got %b expected 1", done_o); end
        val_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_flush();
        test_full_packing();
        test_round_robin();
        test_backpressure();
        test_zero_job();
        test_clear_mid_job();
        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
